// File: rtl/fizzbuzz_monitor.sv
// Monitors a fizz/buzz/fizzbuzz flag stream: hunts for a count-0 anchor, verifies
// LOCK_LEN consecutive matching samples, then flags and counts mismatches while locked.
module fizzbuzz_monitor #(
   parameter int FIZZ       = 3,
   parameter int BUZZ       = 5,
   parameter int MAX_CYCLES = 100,
   parameter int LOCK_LEN   = 8,
   parameter int CNT_W      = 16,
   localparam int PW        = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic             fizz,
   input  logic             buzz,
   input  logic             fizzbuzz,
   input  logic             err_clr,
   output logic             locked,
   output logic [PW-1:0]    phase,
   output logic             err,
   output logic             malformed,
   output logic [CNT_W-1:0] err_count
);

   localparam int FW = (FIZZ > 1) ? $clog2(FIZZ) : 1;
   localparam int BW = (BUZZ > 1) ? $clog2(BUZZ) : 1;
   localparam int MW = $clog2(LOCK_LEN + 1);

   localparam logic [PW-1:0] P_LAST = PW'(MAX_CYCLES - 1);
   localparam logic [FW-1:0] F_LAST = FW'(FIZZ - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BUZZ - 1);
   // The anchor is count 0, so the next expected sample is count 1 (or 0 again if the range is 1).
   localparam logic [PW-1:0] P_ANCH = PW'((MAX_CYCLES == 1) ? 0 : 1);
   localparam logic [FW-1:0] F_ANCH = FW'((MAX_CYCLES == 1) ? 0 : (1 % FIZZ));
   localparam logic [BW-1:0] B_ANCH = BW'((MAX_CYCLES == 1) ? 0 : (1 % BUZZ));
   localparam logic [MW-1:0] M_LOCK = MW'(LOCK_LEN);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t         state, state_nxt;
   logic [PW-1:0]  p, p_nxt, p_adv;
   logic [FW-1:0]  fmod, fmod_nxt, fmod_adv;
   logic [BW-1:0]  bmod, bmod_nxt, bmod_adv;
   logic [MW-1:0]  match_cnt, match_cnt_nxt;
   logic           err_nxt, mal_nxt;
   logic           exp_fizz, exp_buzz, p_wrap;
   logic           is_mal, is_anchor, is_match, do_anchor;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      exp_fizz  = (fmod == '0);
      exp_buzz  = (bmod == '0);
      is_mal    = (fizzbuzz != (fizz & buzz));
      is_anchor = fizz & buzz & fizzbuzz;
      is_match  = !is_mal && (fizz == exp_fizz) && (buzz == exp_buzz)
                  && (fizzbuzz == (exp_fizz & exp_buzz));

      // Modulo counters restart with p on wrap so they never drift when MAX_CYCLES isn't a multiple.
      p_wrap   = (p == P_LAST);
      p_adv    = p_wrap ? '0 : p + 1'b1;
      fmod_adv = (p_wrap || fmod == F_LAST) ? '0 : fmod + 1'b1;
      bmod_adv = (p_wrap || bmod == B_LAST) ? '0 : bmod + 1'b1;

      state_nxt     = state;
      p_nxt         = p;
      fmod_nxt      = fmod;
      bmod_nxt      = bmod;
      match_cnt_nxt = match_cnt;
      err_nxt       = 1'b0;
      mal_nxt       = 1'b0;
      do_anchor     = 1'b0;

      if (in_valid) begin
         case (state)
            HUNT: do_anchor = is_anchor;
            VERIFY: begin
               mal_nxt = is_mal;
               if (is_match) begin
                  p_nxt         = p_adv;
                  fmod_nxt      = fmod_adv;
                  bmod_nxt      = bmod_adv;
                  match_cnt_nxt = match_cnt + 1'b1;
                  if (match_cnt + 1'b1 == M_LOCK)
                     state_nxt = LOCKED;
               end else if (is_anchor) begin
                  do_anchor = 1'b1;
               end else begin
                  state_nxt = HUNT;
               end
            end
            LOCKED: begin
               mal_nxt = is_mal;
               if (is_match) begin
                  p_nxt    = p_adv;
                  fmod_nxt = fmod_adv;
                  bmod_nxt = bmod_adv;
               end else begin
                  err_nxt = 1'b1;
                  if (is_anchor)
                     do_anchor = 1'b1;
                  else
                     state_nxt = HUNT;
               end
            end
            default: state_nxt = HUNT;
         endcase

         if (do_anchor) begin
            p_nxt         = P_ANCH;
            fmod_nxt      = F_ANCH;
            bmod_nxt      = B_ANCH;
            match_cnt_nxt = MW'(1);
            state_nxt     = (LOCK_LEN == 1) ? LOCKED : VERIFY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= HUNT;
         p         <= '0;
         fmod      <= '0;
         bmod      <= '0;
         match_cnt <= '0;
         locked    <= 1'b0;
         phase     <= '0;
         err       <= 1'b0;
         malformed <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         p         <= p_nxt;
         fmod      <= fmod_nxt;
         bmod      <= bmod_nxt;
         match_cnt <= match_cnt_nxt;
         locked    <= (state_nxt == LOCKED);
         phase     <= (state_nxt == HUNT) ? '0 : p_nxt;
         err       <= err_nxt;
         malformed <= mal_nxt;
         if (err_clr)
            err_count <= '0;
         else if (err_nxt)
            err_count <= sat_inc(err_count);
      end
   end

endmodule

// File: tb/tb_fizzbuzz_monitor.sv
// Directed bench for fizzbuzz_monitor: an arithmetic reference model checked every cycle,
// plus literal expectations at the notable points of each scenario.
module tb_fizzbuzz_monitor;

   localparam int FZ = 3;
   localparam int BZ = 5;
   localparam int MC = 100;
   localparam int LL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, in_valid, fizz, buzz, fizzbuzz, err_clr;
   logic        locked, err, malformed;
   logic [6:0]  phase;
   logic [15:0] err_count;
   logic        locked2, err2, malformed2;
   logic [6:0]  phase2;
   logic [1:0]  err_count2;

   fizzbuzz_monitor #(.FIZZ(FZ), .BUZZ(BZ), .MAX_CYCLES(MC), .LOCK_LEN(LL), .CNT_W(16)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .fizz(fizz), .buzz(buzz),
      .fizzbuzz(fizzbuzz), .err_clr(err_clr), .locked(locked), .phase(phase),
      .err(err), .malformed(malformed), .err_count(err_count));

   fizzbuzz_monitor #(.FIZZ(FZ), .BUZZ(BZ), .MAX_CYCLES(MC), .LOCK_LEN(LL), .CNT_W(2)) dut2 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .fizz(fizz), .buzz(buzz),
      .fizzbuzz(fizzbuzz), .err_clr(err_clr), .locked(locked2), .phase(phase2),
      .err(err2), .malformed(malformed2), .err_count(err_count2));

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Reference model: 0 = hunting, 1 = verifying, 2 = locked; m_p is the expected next count.
   int m_st = 0, m_p = 0, m_mc = 0, m_ec16 = 0, m_ec2 = 0;
   bit m_err = 1'b0, m_mal = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit v, input bit f, input bit b, input bit fb,
                             input bit clr, input bit rst);
      bit ef, eb, mal, anc, mt, do_anc;
      if (!rst) begin
         m_st = 0; m_p = 0; m_mc = 0; m_err = 0; m_mal = 0; m_ec16 = 0; m_ec2 = 0;
         return;
      end
      m_err = 0; m_mal = 0; do_anc = 0;
      if (v) begin
         ef  = (m_p % FZ) == 0;
         eb  = (m_p % BZ) == 0;
         mal = fb != (f & b);
         anc = f & b & fb;
         mt  = !mal && f == ef && b == eb && fb == (ef & eb);
         if (m_st == 0) begin
            do_anc = anc;
         end else begin
            m_mal = mal;
            if (mt) begin
               m_p = (m_p + 1) % MC;
               if (m_st == 1) begin
                  m_mc++;
                  if (m_mc == LL) m_st = 2;
               end
            end else begin
               if (m_st == 2) m_err = 1;
               if (anc) do_anc = 1;
               else m_st = 0;
            end
         end
         if (do_anc) begin
            m_p = 1; m_mc = 1; m_st = (LL == 1) ? 2 : 1;
         end
      end
      if (clr) begin
         m_ec16 = 0; m_ec2 = 0;
      end else if (m_err) begin
         if (m_ec16 < 65535) m_ec16++;
         if (m_ec2 < 3) m_ec2++;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("locked", int'(locked), int'(m_st == 2));
         check("phase", int'(phase), (m_st == 0) ? 0 : m_p);
         check("err", int'(err), int'(m_err));
         check("malformed", int'(malformed), int'(m_mal));
         check("err_count", int'(err_count), m_ec16);
         check("locked_w2", int'(locked2), int'(m_st == 2));
         check("err_count_w2", int'(err_count2), m_ec2);
      end
   end

   task automatic raw(input bit v, input bit f, input bit b, input bit fb,
                      input bit clr, input bit rst);
      in_valid = v; fizz = f; buzz = b; fizzbuzz = fb; err_clr = clr; resetn = rst;
      @(posedge clk);
      model_step(v, f, b, fb, clr, rst);
      @(negedge clk);
   endtask

   task automatic send(input int c);
      raw(1'b1, (c % FZ) == 0, (c % BZ) == 0, (c % (FZ * BZ)) == 0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      raw(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      raw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; fizzbuzz = 1'b0; err_clr = 1'b0;
      do_reset();
      chk_en = 1'b1;
      check("rst_locked", int'(locked), 0);
      check("rst_phase", int'(phase), 0);
      check("rst_err_count", int'(err_count), 0);

      // Golden stream from count 0, continuous, across wraps.
      for (int c = 0; c < 8; c++) send(c);
      check("gold_locked", int'(locked), 1);
      check("gold_phase", int'(phase), 8);
      for (int i = 8; i < 300; i++) send(i % MC);
      check("gold_err_count", int'(err_count), 0);
      check("gold_phase_end", int'(phase), 0);

      // Golden stream with gaps; junk anchor flags while invalid must be ignored.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) send(i / 2);
         else raw(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      end
      check("gap_locked", int'(locked), 1);
      check("gap_phase", int'(phase), 8);

      // Stream starting mid-range: false anchor at 45, error on the wrap.
      do_reset();
      for (int c = 37; c < 100; c++) send(c);
      check("mid_locked", int'(locked), 1);
      check("mid_phase", int'(phase), 55);
      send(0);
      check("mid_err", int'(err), 1);
      check("mid_err_count", int'(err_count), 1);
      check("mid_unlocked", int'(locked), 0);
      check("mid_reanchor_phase", int'(phase), 1);
      for (int c = 1; c < 8; c++) send(c);
      check("mid_relocked", int'(locked), 1);

      // Fizz flipped at 21, malformed ignored in hunt, relock from anchor at 30.
      do_reset();
      for (int c = 0; c < 21; c++) send(c);
      check("flip_prelocked", int'(locked), 1);
      raw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("flip_err", int'(err), 1);
      check("flip_err_count", int'(err_count), 1);
      check("flip_unlocked", int'(locked), 0);
      check("flip_phase", int'(phase), 0);
      raw(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("hunt_malformed", int'(malformed), 0);
      for (int c = 23; c < 30; c++) send(c);
      check("hunt_unlocked", int'(locked), 0);
      for (int c = 30; c < 38; c++) send(c);
      check("flip_relocked", int'(locked), 1);
      check("flip_relock_phase", int'(phase), 8);

      // Malformed (1,1,0) while locked.
      raw(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("mal_malformed", int'(malformed), 1);
      check("mal_err", int'(err), 1);
      check("mal_err_count", int'(err_count), 2);
      check("mal_unlocked", int'(locked), 0);

      // Saturation in the narrow counter, clear priority, reset mid-lock.
      do_reset();
      for (int c = 0; c < 8; c++) send(c);
      for (int k = 1; k <= 6; k++) begin
         raw(1'b1, 1'b1, 1'b1, 1'b1, k == 5, 1'b1);
         if (k == 4) begin
            check("sat_err_count_w2", int'(err_count2), 3);
            check("sat_err_count_w16", int'(err_count), 4);
         end
         if (k == 5) begin
            check("clr_err", int'(err), 1);
            check("clr_err_count_w2", int'(err_count2), 0);
            check("clr_err_count_w16", int'(err_count), 0);
         end
         for (int c = 1; c < 8; c++) send(c);
      end
      check("pre_rst_locked", int'(locked), 1);
      check("pre_rst_err_count", int'(err_count), 1);
      raw(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("midrst_locked", int'(locked), 0);
      check("midrst_phase", int'(phase), 0);
      check("midrst_err_count", int'(err_count), 0);
      check("midrst_err_count_w2", int'(err_count2), 0);
      raw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
